// File: rtl/hazard_ctrl_pkg.sv
// Package: hazard_ctrl_pkg
// Shared pipeline hazard types, constants and the operand-forwarding selector.
//   creg_addr_t : 5-bit architectural register address (0 = unused / x0)
//   fwd_sel_t   : E-stage operand source (register file, M result, W result)
//   hz_state_t  : hazard sequencer states
//   fwd_select  : forwarding source for one E-stage read address
package hazard_ctrl_pkg;

    localparam int MC_CYCLES_DEFAULT = 32;

    typedef logic [4:0] creg_addr_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_M  = 2'b01,
        FWD_W  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_MC,
        HZ_DRAIN
    } hz_state_t;

    // The M stage holds the younger result, so it takes priority over W.
    // Register 0 is never forwarded because it is hardwired to zero.
    function automatic fwd_sel_t fwd_select(
        input creg_addr_t ra,
        input creg_addr_t dst_m,
        input logic       wr_m,
        input creg_addr_t dst_w,
        input logic       wr_w
    );
        if (wr_m && (dst_m != '0) && (dst_m == ra)) begin
            return FWD_M;
        end else if (wr_w && (dst_w != '0) && (dst_w == ra)) begin
            return FWD_W;
        end else begin
            return FWD_RF;
        end
    endfunction

endpackage

// File: rtl/hazard_ctrl_mc_timer.sv
// Module: mc_timer
// Loadable down-counter that times a multi-cycle E-stage operation.
// Ports:
//   clk        in  clock
//   reset      in  synchronous active-high reset, clears the count
//   load       in  load load_value this cycle (takes priority over dec)
//   dec        in  decrement this cycle; holding both low freezes the count
//   load_value in  WIDTH-bit starting value
//   zero       out count is zero
module mc_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Saturates at zero so a stray dec can never wrap into a long stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Module: hazard_ctrl
// Stall / flush / forward sequencer for the 5-stage pipeline (F, D, E, M, W).
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   ra1D, ra2D                  read addresses of the instruction in D
//   ra1E, ra2E                  read addresses of the instruction in E
//   dstE, dstM, dstW            destination registers in E, M, W
//   regwriteE/M/W               stage writes its destination
//   memreadE                    instruction in E is a load
//   mc_startE                   first E cycle of a multi-cycle op
//   branch_takenE               E resolved a taken branch/jump
//   i_busy, i_data_ok           instruction fetch outstanding / returning
//   d_wait                      M-stage memory access not complete
//   stallF/D/E/M                hold the corresponding pipeline register
//   flushD/E/W                  load a bubble into the register feeding D/E/W
//   fwd_a, fwd_b                E operand forwarding selects
//   tgt_capture, pc_redirect    branch target latch / PC load strobes
//   mc_done                     one-cycle pulse: multi-cycle result valid in E
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MC_CYCLES = MC_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  creg_addr_t ra1D,
    input  creg_addr_t ra2D,
    input  creg_addr_t ra1E,
    input  creg_addr_t ra2E,
    input  creg_addr_t dstE,
    input  creg_addr_t dstM,
    input  creg_addr_t dstW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memreadE,
    input  logic       mc_startE,
    input  logic       branch_takenE,
    input  logic       i_busy,
    input  logic       i_data_ok,
    input  logic       d_wait,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushD,
    output logic       flushE,
    output logic       flushW,
    output fwd_sel_t   fwd_a,
    output fwd_sel_t   fwd_b,
    output logic       tgt_capture,
    output logic       pc_redirect,
    output logic       mc_done
);

    localparam int              CW      = $clog2(MC_CYCLES);
    // The start cycle already counts as the first E cycle, and the final
    // (count == 0) cycle is the mc_done cycle, hence MC_CYCLES-2.
    localparam logic [CW-1:0]   MC_LOAD = CW'(MC_CYCLES - 2);

    hz_state_t state;
    hz_state_t state_next;
    logic      tmr_load;
    logic      tmr_dec;
    logic      tmr_zero;
    logic      loaduse;

    // regwriteE is part of the stage interface; the load-use term keys off
    // memreadE alone, since every load writes its destination.
    logic      unused_regwrite_e;
    assign unused_regwrite_e = regwriteE;

    assign loaduse = memreadE && (dstE != '0) && ((dstE == ra1D) || (dstE == ra2D));

    mc_timer #(
        .WIDTH (CW)
    ) u_mc_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .dec        (tmr_dec),
        .load_value (MC_LOAD),
        .zero       (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HZ_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        stallF      = 1'b0;
        stallD      = 1'b0;
        stallE      = 1'b0;
        stallM      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        flushW      = 1'b0;
        tgt_capture = 1'b0;
        pc_redirect = 1'b0;
        mc_done     = 1'b0;
        fwd_a       = fwd_select(ra1E, dstM, regwriteM, dstW, regwriteW);
        fwd_b       = fwd_select(ra2E, dstM, regwriteM, dstW, regwriteW);

        if (reset) begin
            fwd_a = FWD_RF;
            fwd_b = FWD_RF;
        end else if (d_wait) begin
            // Whole pipe holds; W gets a bubble so the stalled M result is
            // not written twice. FSM and timer stay frozen.
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else begin
            case (state)
                HZ_MC: begin
                    if (tmr_zero) begin
                        mc_done    = 1'b1;
                        state_next = HZ_RUN;
                    end else begin
                        stallF  = 1'b1;
                        stallD  = 1'b1;
                        stallE  = 1'b1;
                        tmr_dec = 1'b1;
                    end
                end
                HZ_DRAIN: begin
                    // The fetch in flight is wrong-path; its data is dropped
                    // by bubbling D until it returns.
                    stallF = 1'b1;
                    flushD = 1'b1;
                    if (i_data_ok) begin
                        pc_redirect = 1'b1;
                        state_next  = HZ_RUN;
                    end
                end
                default: begin
                    if (mc_startE) begin
                        stallF     = 1'b1;
                        stallD     = 1'b1;
                        stallE     = 1'b1;
                        tmr_load   = 1'b1;
                        state_next = HZ_MC;
                    end else if (branch_takenE) begin
                        flushD      = 1'b1;
                        flushE      = 1'b1;
                        tgt_capture = 1'b1;
                        if (i_busy) begin
                            stallF     = 1'b1;
                            state_next = HZ_DRAIN;
                        end else begin
                            pc_redirect = 1'b1;
                        end
                    end else if (loaduse) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flushE = 1'b1;
                    end else if (i_busy) begin
                        stallF = 1'b1;
                        flushD = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
